// File: rtl/edge_locator.sv
// Strongest-edge finder for 5-pixel beats: 3-stage pipeline (capture, gap max,
// confirm FSM + output register) with a valid/ready event output.

module edge_gap #(
  parameter int PIXEL_W = 8
) (
  input  logic [PIXEL_W-1:0] a,
  input  logic [PIXEL_W-1:0] b,
  output logic [PIXEL_W-1:0] diff,
  output logic               rising
);
  always_comb begin
    rising = (b > a);
    diff   = rising ? (b - a) : (a - b);
  end
endmodule

module edge_locator #(
  parameter int PIXEL_W       = 8,
  parameter int NUM_PIXELS    = 5,
  parameter int THRESHOLD     = 32,
  parameter int CONFIRM_COUNT = 3,
  localparam int GAPS  = NUM_PIXELS - 1,
  localparam int POS_W = (GAPS > 1) ? $clog2(GAPS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_PIXELS*PIXEL_W-1:0] in_pixels,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [POS_W-1:0]              out_position,
  output logic [PIXEL_W-1:0]            out_magnitude,
  output logic                          out_rising,
  output logic [15:0]                   edge_count
);
  localparam int CNT_W = $clog2(CONFIRM_COUNT + 1);
  localparam logic [PIXEL_W-1:0] THR  = PIXEL_W'(THRESHOLD);
  localparam logic [CNT_W-1:0]   CONF = CNT_W'(CONFIRM_COUNT);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  logic advance;

  // vld_pipe bit 1 = S1 (pixels), bit 2 = S2 (max difference)
  logic [2:1] vld_pipe_q, vld_pipe_d;
  logic [NUM_PIXELS-1:0][PIXEL_W-1:0] pix_q, pix_d;

  logic [GAPS-1:0][PIXEL_W-1:0] gap_diff;
  logic [GAPS-1:0]              gap_rise;
  logic [PIXEL_W-1:0]           max_mag;
  logic [POS_W-1:0]             max_pos;
  logic                         max_rise;

  logic [PIXEL_W-1:0] mag_q, mag_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               rise_q, rise_d;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   trk_pos_q, trk_pos_d;
  logic               trk_rise_q, trk_rise_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               emit, cand, same;

  logic               out_valid_q, out_valid_d;
  logic [POS_W-1:0]   out_pos_q, out_pos_d;
  logic [PIXEL_W-1:0] out_mag_q, out_mag_d;
  logic               out_rise_q, out_rise_d;
  logic [15:0]        edge_count_q, edge_count_d;

  assign in_ready      = !out_valid_q || out_ready;
  assign advance       = in_ready;
  assign out_valid     = out_valid_q;
  assign out_position  = out_pos_q;
  assign out_magnitude = out_mag_q;
  assign out_rising    = out_rise_q;
  assign edge_count    = edge_count_q;

  for (genvar g = 0; g < GAPS; g++) begin : g_gap
    edge_gap #(.PIXEL_W(PIXEL_W)) u_gap (
      .a      (pix_q[g]),
      .b      (pix_q[g+1]),
      .diff   (gap_diff[g]),
      .rising (gap_rise[g])
    );
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    max_mag  = gap_diff[0];
    max_pos  = '0;
    max_rise = gap_rise[0];
    for (int i = 1; i < GAPS; i++) begin
      if (gap_diff[i] > max_mag) begin
        max_mag  = gap_diff[i];
        max_pos  = POS_W'(i);
        max_rise = gap_rise[i];
      end
    end
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    pix_d      = pix_q;
    mag_d      = mag_q;
    pos_d      = pos_q;
    rise_d     = rise_q;
    if (advance) begin
      vld_pipe_d = {vld_pipe_q[1], in_valid};
      if (in_valid) pix_d = in_pixels;
      if (vld_pipe_q[1]) begin
        mag_d  = max_mag;
        pos_d  = max_pos;
        rise_d = max_rise;
      end
    end
  end

  assign cand = vld_pipe_q[2] && (mag_q >= THR);
  assign same = (pos_q == trk_pos_q) && (rise_q == trk_rise_q);

  always_comb begin
    state_d    = state_q;
    trk_pos_d  = trk_pos_q;
    trk_rise_d = trk_rise_q;
    cnt_d      = cnt_q;
    emit       = 1'b0;
    if (advance && vld_pipe_q[2]) begin
      if (!cand) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (state_q == IDLE || !same) begin
        trk_pos_d  = pos_q;
        trk_rise_d = rise_q;
        cnt_d      = CNT_W'(1);
        if (CONFIRM_COUNT == 1) begin
          emit    = 1'b1;
          state_d = LOCKED;
        end else begin
          state_d = TRACK;
        end
      end else if (state_q == TRACK) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CONF) begin
          emit    = 1'b1;
          state_d = LOCKED;
        end
      end
    end
  end

  // While stalled the event holds; on any advance the old event was consumed.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pos_d    = out_pos_q;
    out_mag_d    = out_mag_q;
    out_rise_d   = out_rise_q;
    edge_count_d = edge_count_q;
    if (advance) out_valid_d = emit;
    if (emit) begin
      out_pos_d  = pos_q;
      out_mag_d  = mag_q;
      out_rise_d = rise_q;
      if (edge_count_q != 16'hFFFF) edge_count_d = edge_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe_q   <= '0;
      pix_q        <= '0;
      mag_q        <= '0;
      pos_q        <= '0;
      rise_q       <= 1'b0;
      state_q      <= IDLE;
      trk_pos_q    <= '0;
      trk_rise_q   <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_pos_q    <= '0;
      out_mag_q    <= '0;
      out_rise_q   <= 1'b0;
      edge_count_q <= '0;
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      pix_q        <= pix_d;
      mag_q        <= mag_d;
      pos_q        <= pos_d;
      rise_q       <= rise_d;
      state_q      <= state_d;
      trk_pos_q    <= trk_pos_d;
      trk_rise_q   <= trk_rise_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_pos_q    <= out_pos_d;
      out_mag_q    <= out_mag_d;
      out_rise_q   <= out_rise_d;
      edge_count_q <= edge_count_d;
    end
  end

endmodule

// File: tb/tb_edge_locator.sv
// Directed + randomized bench for edge_locator; reference model works on whole
// beats (max gap, run length of identical candidates).

module tb_edge_locator;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] in_pixels = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_position;
  logic [7:0]  out_magnitude;
  logic        out_rising;
  logic [15:0] edge_count;

  edge_locator dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixels(in_pixels), .out_valid(out_valid), .out_ready(out_ready),
    .out_position(out_position), .out_magnitude(out_magnitude),
    .out_rising(out_rising), .edge_count(edge_count)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [1:0] pos; logic [7:0] mag; logic rise; } ev_t;

  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  int  exp_cnt = 0;
  int  acc_cnt = 0;
  int  run = 0;
  int  rpos = 0;
  bit  rrise = 0;

  function automatic logic [39:0] pk(input int a, input int b, input int c, input int d, input int e);
    return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // An edge is reported when the run of identical candidates reaches exactly 3.
  task automatic model_step(input logic [39:0] px);
    int p[5];
    int best, bpos, d, ad;
    bit br;
    ev_t ev;
    for (int i = 0; i < 5; i++) p[i] = int'(px[i*8 +: 8]);
    best = -1; bpos = 0; br = 0;
    for (int i = 0; i < 4; i++) begin
      d  = p[i+1] - p[i];
      ad = (d < 0) ? -d : d;
      if (ad > best) begin best = ad; bpos = i; br = (d > 0); end
    end
    if (best < 32) run = 0;
    else if (run > 0 && bpos == rpos && br == rrise) run++;
    else begin run = 1; rpos = bpos; rrise = br; end
    if (best >= 32 && run == 3) begin
      ev.pos = 2'(bpos); ev.mag = 8'(best); ev.rise = br;
      exp_q.push_back(ev);
      if (exp_cnt < 65535) exp_cnt++;
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete(); obs_q.delete();
      exp_cnt = 0; acc_cnt = 0; run = 0;
    end else begin
      if (out_valid && out_ready) obs_q.push_back({out_position, out_magnitude, out_rising});
      if (in_valid && in_ready) begin
        acc_cnt++;
        model_step(in_pixels);
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Returns at 1 time unit after the accepting edge.
  task automatic send_beat(input logic [39:0] px);
    int waited = 0;
    in_valid = 1'b1; in_pixels = px;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        checks++; errors++;
        $display("FAIL send_beat timeout: in_ready=%0b required 1", in_ready);
        break;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({out_valid, out_position, out_magnitude, out_rising, edge_count, in_ready} !== {1'b0, 2'd0, 8'd0, 1'b0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: valid=%0b pos=%0d mag=%0d rise=%0b cnt=%0d rdy=%0b required 0,0,0,0,0,1",
               out_valid, out_position, out_magnitude, out_rising, edge_count, in_ready);
    end
  endtask

  task automatic test_flat();
    int seen = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      send_beat(pk(10, 10, 10, 10, 10));
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL flat_in_ready: got %0b required 1", in_ready); end
      if (out_valid) seen++;
    end
    drain();
    checks++;
    if (seen != 0 || edge_count !== 16'd0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL flat_no_event: valid_seen=%0d cnt=%0d events=%0d required 0,0,0", seen, edge_count, obs_q.size());
    end
  endtask

  task automatic test_rising();
    apply_reset();
    for (int i = 0; i < 3; i++) send_beat(pk(10, 10, 200, 200, 200));
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rise_lat_k: out_valid=%0b required 0", out_valid); end
    send_beat(pk(10, 10, 200, 200, 200));
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rise_lat_k1: out_valid=%0b required 0", out_valid); end
    send_beat(pk(10, 10, 200, 200, 200));
    checks++;
    if ({out_valid, out_position, out_magnitude, out_rising, edge_count} !== {1'b1, 2'd1, 8'd190, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL rise_lat_k2: valid=%0b pos=%0d mag=%0d rise=%0b cnt=%0d required 1,1,190,1,1",
               out_valid, out_position, out_magnitude, out_rising, edge_count);
    end
    drain();
    checks++;
    if (obs_q.size() != 1 || edge_count !== 16'd1) begin
      errors++; $display("FAIL rise_count: events=%0d cnt=%0d required 1,1", obs_q.size(), edge_count);
    end
  endtask

  task automatic test_noise();
    apply_reset();
    send_beat(pk(10, 10, 200, 200, 200));
    send_beat(pk(10, 10, 200, 200, 200));
    send_beat(pk(10, 10, 10, 10, 10));
    send_beat(pk(10, 10, 200, 200, 200));
    send_beat(pk(10, 10, 200, 200, 200));
    drain();
    checks++;
    if (obs_q.size() != 0 || edge_count !== 16'd0) begin
      errors++; $display("FAIL noise_reject: events=%0d cnt=%0d required 0,0", obs_q.size(), edge_count);
    end
  endtask

  task automatic test_position();
    apply_reset();
    send_beat(pk(10, 10, 200, 200, 200));
    send_beat(pk(10, 10, 200, 200, 200));
    for (int i = 0; i < 3; i++) send_beat(pk(200, 200, 200, 200, 5));
    drain();
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL pos_change_count: events=%0d required 1", obs_q.size());
    end else if (obs_q[0] !== ev_t'({2'd3, 8'd195, 1'b0})) begin
      errors++;
      $display("FAIL pos_change_event: pos=%0d mag=%0d rise=%0b required 3,195,0", obs_q[0].pos, obs_q[0].mag, obs_q[0].rise);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(pk(10, 10, 200, 200, 200));
    in_pixels = pk(10, 10, 10, 10, 10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, in_ready, out_position, out_magnitude, out_rising, edge_count} !== {1'b1, 1'b0, 2'd1, 8'd190, 1'b1, 16'd1}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%0b rdy=%0b pos=%0d mag=%0d rise=%0b cnt=%0d required 1,0,1,190,1,1",
                 i, out_valid, in_ready, out_position, out_magnitude, out_rising, edge_count);
      end
      @(posedge clock); #1;
    end
    checks++;
    if (acc_cnt != 5) begin errors++; $display("FAIL bp_accepts: got %0d required 5", acc_cnt); end
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || acc_cnt != 6 || obs_q.size() != 1) begin
      errors++; $display("FAIL bp_release: valid=%0b accepts=%0d events=%0d required 0,6,1", out_valid, acc_cnt, obs_q.size());
    end
    for (int i = 0; i < 3; i++) send_beat(pk(10, 10, 200, 200, 200));
    drain();
    checks++;
    if (obs_q.size() != 2 || edge_count !== 16'd2) begin
      errors++; $display("FAIL bp_resume: events=%0d cnt=%0d required 2,2", obs_q.size(), edge_count);
    end
  endtask

  task automatic test_boundaries();
    apply_reset();
    for (int i = 0; i < 3; i++) send_beat(pk(0, 31, 62, 93, 124));
    drain();
    checks++;
    if (obs_q.size() != 0 || edge_count !== 16'd0) begin
      errors++; $display("FAIL below_threshold: events=%0d cnt=%0d required 0,0", obs_q.size(), edge_count);
    end
    apply_reset();
    for (int i = 0; i < 3; i++) send_beat(pk(0, 32, 64, 96, 128));
    drain();
    checks++;
    if (obs_q.size() != 1 || edge_count !== 16'd1) begin
      errors++; $display("FAIL at_threshold_count: events=%0d cnt=%0d required 1,1", obs_q.size(), edge_count);
    end else if (obs_q[0] !== ev_t'({2'd0, 8'd32, 1'b1})) begin
      errors++;
      $display("FAIL tie_lowest: pos=%0d mag=%0d rise=%0b required 0,32,1", obs_q[0].pos, obs_q[0].mag, obs_q[0].rise);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_beat(pk(10, 10, 200, 200, 200));
    send_beat(pk(10, 10, 200, 200, 200));
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    send_beat(pk(10, 10, 200, 200, 200));
    drain();
    checks++;
    if (obs_q.size() != 0 || edge_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid: events=%0d cnt=%0d required 0,0", obs_q.size(), edge_count);
    end
  endtask

  task automatic test_random();
    logic [39:0] pats[5];
    int sel = 0;
    int n;
    apply_reset();
    pats[0] = pk(10, 10, 10, 10, 10);
    pats[1] = pk(10, 10, 200, 200, 200);
    pats[2] = pk(200, 200, 200, 200, 5);
    pats[3] = pk(0, 32, 64, 96, 128);
    pats[4] = pk(90, 40, 40, 40, 40);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) sel = $urandom_range(4);
      in_valid  = ($urandom_range(3) != 0);
      in_pixels = ($urandom_range(9) == 0) ? 40'({$urandom, $urandom}) : pats[sel];
      out_ready = ($urandom_range(3) != 0);
      @(posedge clock); #1;
    end
    drain();
    checks++;
    if (obs_q.size() != exp_q.size() || edge_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL rand_count: events=%0d cnt=%0d required %0d,%0d", obs_q.size(), edge_count, exp_q.size(), exp_cnt);
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_event[%0d]: pos=%0d mag=%0d rise=%0b required %0d,%0d,%0b",
                 i, obs_q[i].pos, obs_q[i].mag, obs_q[i].rise, exp_q[i].pos, exp_q[i].mag, exp_q[i].rise);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_rising();
    test_noise();
    test_position();
    test_backpressure();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
